// File: rtl/toggle_monitor_pkg.sv
// rtl/toggle_monitor_pkg.sv - shared types, defaults and width helper for toggle_monitor
package toggle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } tm_state_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_WINDOW = 256;

  // Window counter never narrower than one bit, even for tiny windows.
  function automatic int unsigned win_cnt_w(input int unsigned window);
    int unsigned w;
    w = $clog2(window);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// rtl/toggle_edge_detect.sv - per-channel input stage and rising-edge pulse
// TOGGLE_MONITOR_SYNC_EN selects a 2-flop synchronizer instead of a single register stage.
module toggle_edge_detect
  import toggle_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tog,
  output logic rise
);

  logic cur;
  logic prev;

`ifdef TOGGLE_MONITOR_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      cur  <= 1'b0;
    end else begin
      meta <= tog;
      cur  <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= 1'b0;
    end else begin
      cur <= tog;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/toggle_monitor.sv
// rtl/toggle_monitor.sv - windowed per-channel rising-edge counter with valid/ready snapshot
// Input stage depth depends on TOGGLE_MONITOR_SYNC_EN (see toggle_edge_detect).
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       tog_i,
  output logic [NUM_CH*CNT_W-1:0] cnt_o,
  output logic [NUM_CH-1:0]       sat_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int unsigned       WIN_W    = win_cnt_w(WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  tm_state_e                     state;
  tm_state_e                     state_next;
  logic [WIN_W-1:0]              win_cnt;
  logic [NUM_CH-1:0]             rise;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_next;
  logic [NUM_CH-1:0]             sat;
  logic [NUM_CH-1:0]             sat_next;
  logic                          win_done;
  logic                          xfer;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    toggle_edge_detect u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .tog  (tog_i[k]),
      .rise (rise[k])
    );
  end

  assign win_done = (win_cnt == WIN_LAST);
  assign xfer     = valid_o & ready_i;

  // Dropping en aborts a window outright; a pending report is always delivered first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = MEASURE;
      MEASURE: begin
        if (!en)          state_next = IDLE;
        else if (win_done) state_next = REPORT;
      end
      REPORT:  if (xfer) state_next = en ? MEASURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    sat_next = sat;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rise[k]) begin
        if (cnt[k] == CNT_MAX) sat_next[k] = 1'b1;
        else                   cnt_next[k] = cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      cnt     <= '0;
      sat     <= '0;
      cnt_o   <= '0;
      sat_o   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_next;
      busy_o  <= (state_next == MEASURE);
      valid_o <= (state_next == REPORT);

      if (state == MEASURE && state_next == MEASURE) win_cnt <= win_cnt + 1'b1;
      else                                           win_cnt <= '0;

      // Working counters only hold data inside MEASURE, so they re-enter it cleared.
      if (state == MEASURE) begin
        cnt <= cnt_next;
        sat <= sat_next;
      end else begin
        cnt <= '0;
        sat <= '0;
      end

      // Snapshot uses next-values so an event on the last window cycle is included.
      if (state == MEASURE && state_next == REPORT) begin
        cnt_o <= cnt_next;
        sat_o <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// tb/tb_toggle_monitor.sv - scoreboard bench for toggle_monitor (CNT_W=8 and CNT_W=3 instances)
module tb_toggle_monitor;

  localparam int NUM_CH = 4;
  localparam int WINDOW = 16;
`ifdef TOGGLE_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, ready;
  logic tog0, tog1, tog2;
  logic run0 = 1'b0;
  logic run1 = 1'b0;
  logic [NUM_CH-1:0] tog;
  assign tog = {1'b0, tog2, tog1, tog0};

  logic [NUM_CH*8-1:0] cnt8;
  logic [NUM_CH-1:0]   sat8;
  logic                valid8, busy8;
  logic [NUM_CH*3-1:0] cnt3;
  logic [NUM_CH-1:0]   sat3;
  logic                valid3, busy3;

  toggle_monitor #(.NUM_CH(NUM_CH), .CNT_W(8), .WINDOW(WINDOW)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .tog_i(tog), .cnt_o(cnt8), .sat_o(sat8),
    .valid_o(valid8), .ready_i(ready), .busy_o(busy8)
  );

  toggle_monitor #(.NUM_CH(NUM_CH), .CNT_W(3), .WINDOW(WINDOW)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .tog_i(tog), .cnt_o(cnt3), .sat_o(sat3),
    .valid_o(valid3), .ready_i(ready), .busy_o(busy3)
  );

  typedef struct {
    logic [NUM_CH*8-1:0] c8;
    logic [NUM_CH-1:0]   s8;
    logic [NUM_CH*3-1:0] c3;
    logic [NUM_CH-1:0]   s3;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Hand counts per channel; the 3-bit instance clamps at 7 and flags saturation above it.
  task automatic expect_snap(input int c0, input int c1, input int c2, input int c3v);
    exp_t e;
    int   c[4];
    c = '{c0, c1, c2, c3v};
    for (int k = 0; k < NUM_CH; k++) begin
      e.c8[k*8 +: 8] = 8'(c[k]);
      e.s8[k]        = 1'b0;
      e.c3[k*3 +: 3] = (c[k] > 7) ? 3'd7 : 3'(c[k]);
      e.s3[k]        = (c[k] > 7);
    end
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 4 * WINDOW; i++) begin
      @(posedge clk);
      #1;
      if (valid8) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {valid8, valid3}, 0);
    check({tag, "_busy"},  {busy8, busy3}, 0);
    check({tag, "_cnt"},   {cnt8, cnt3}, 0);
    check({tag, "_sat"},   {sat8, sat3}, 0);
  endtask

  initial begin
    tog0 = 1'b0;
    tog1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog0 = run0 ? ~tog0 : 1'b0;
      tog1 = run1 ? ~tog1 : 1'b0;
    end
  end

  // Monitor: compares every cycle valid is high, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (valid8 || valid3)) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {valid8, valid3}, 0);
        end else begin
          check("cnt8", cnt8, sb[0].c8);
          check("sat8", sat8, sb[0].s8);
          check("cnt3", cnt3, sb[0].c3);
          check("sat3", sat3, sb[0].s3);
          check("valid_busy", {valid3, busy8, busy3}, 3'b100);
          if (ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b1;
    en    = 1'b0;
    ready = 1'b1;
    tog2  = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    step(3);
    rst_n = 1'b1;
    step(2);

    // ch0 toggling every cycle, single window
    run0 = 1'b1;
    step(4);
    en = 1'b1;
    expect_snap(8, 0, 0, 0);
    step(1);
    check("busy_rise", busy8, 1);
    wait_valid(cyc);
    check("window_len", cyc, WINDOW);
    en = 1'b0;
    step(1);
    check("valid_one_cycle", valid8, 0);
    check("idle_busy", busy8, 0);

    // ch1 toggling, two back-to-back windows (saturation on 3-bit instance)
    run0 = 1'b0;
    run1 = 1'b1;
    step(4);
    en = 1'b1;
    expect_snap(0, 8, 0, 0);
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    check("first_window", cyc, WINDOW + 1);
    wait_valid(cyc);
    check("b2b_period", cyc, WINDOW + 1);
    en = 1'b0;
    step(1);

    // stall 10 cycles with toggling continuing, en bouncing while in REPORT
    step(4);
    ready = 1'b0;
    en = 1'b1;
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) en = 1'b0;
      if (i == 7) en = 1'b1;
      step(1);
      check("stall_valid", valid8, 1);
    end
    ready = 1'b1;
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    check("post_stall_window", cyc, WINDOW + 1);
    en = 1'b0;
    step(1);

    // abort mid-window
    step(4);
    en = 1'b1;
    step(8);
    en = 1'b0;
    step(1);
    check("abort_idle", busy8, 0);
    step(WINDOW + 4);
    check("abort_no_report", valid8, 0);
    en = 1'b1;
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    check("reenable_window", cyc, WINDOW + 1);
    en = 1'b0;
    step(1);

    // async reset mid-MEASURE
    step(4);
    en = 1'b1;
    step(6);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 check_zero("rst_meas");
    step(2);
    rst_n = 1'b1;
    step(4);

    // async reset mid-REPORT
    ready = 1'b0;
    en = 1'b1;
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    step(3);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 check_zero("rst_rep");
    sb.delete();
    step(2);
    rst_n = 1'b1;
    ready = 1'b1;
    step(4);
    en = 1'b1;
    expect_snap(0, 8, 0, 0);
    wait_valid(cyc);
    check("post_reset_window", cyc, WINDOW + 1);
    en = 1'b0;
    step(1);

    // single step on ch2 landing on the last MEASURE cycle
    run1 = 1'b0;
    step(4);
    en = 1'b1;
    expect_snap(0, 0, 1, 0);
    step(WINDOW - LAT + 1);
    tog2 = 1'b1;
    wait_valid(cyc);
    check("edge_last_cycle", cyc, LAT);
    en = 1'b0;
    step(1);
    tog2 = 1'b0;
    step(4);

    // same step one cycle later falls into REPORT and is dropped
    en = 1'b1;
    expect_snap(0, 0, 0, 0);
    step(WINDOW - LAT + 2);
    tog2 = 1'b1;
    wait_valid(cyc);
    check("edge_after_window", cyc, LAT - 1);
    en = 1'b0;
    step(1);
    tog2 = 1'b0;

    step(3);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
